onehot_scan_decoder: RTL and testbench
======================================

ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

Interface
REQ-001 The block SHALL have parameter SEL_W, default 2: select width; output width is 2**SEL_W.
REQ-002 The block SHALL have parameter DWELL_W, default 4: width of the scan dwell count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: global enable; low freezes all state.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct decode, 1 = auto-scan.
REQ-007 The block SHALL have port din_valid, input, 1 bit: din is offered.
REQ-008 The block SHALL have port din, input, SEL_W bits: index to decode.
REQ-009 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-010 The block SHALL have port ch_mask, input, 2**SEL_W bits: channels eligible for scan.
REQ-011 The block SHALL have port dwell, input, DWELL_W bits: extra cycles each scan channel is held.
REQ-012 The block SHALL have port dout, output, 2**SEL_W bits: registered one-hot (or zero) output.
REQ-013 The block SHALL have port dout_valid, output, 1 bit: dout holds a valid decode.
REQ-014 The block SHALL have port err, output, 1 bit: scan requested with an empty mask.

Function
REQ-015 The FSM SHALL have states IDLE, DIRECT, SCAN and HALT; all outputs SHALL be registered, except din_ready.
REQ-016 When en=0 the state, dout, dout_valid, err and the scan pointer/counter SHALL hold, and din_ready SHALL be 0.
REQ-017 din_ready SHALL equal en AND (mode=0), combinationally.
REQ-018 From any state, at a clock edge with en=1 and mode=0, the state SHALL go to DIRECT.
REQ-019 From any state other than SCAN, at a clock edge with en=1 and mode=1: if ch_mask is nonzero, the state SHALL go to SCAN; otherwise it SHALL go to HALT.
REQ-020 In DIRECT, an accept (din_valid AND din_ready) SHALL load dout = 1<<din and dout_valid=1 on that edge (1-cycle latency).
REQ-021 In DIRECT without an accept, dout and dout_valid SHALL hold.
REQ-022 On entry to DIRECT, dout SHALL hold its prior value until the first accept.
REQ-023 Every dout value SHALL be all-zero or exactly one-hot.
REQ-024 On entry to SCAN, ptr SHALL be set to the lowest set bit of ch_mask, dout SHALL be 1<<ptr, dout_valid SHALL be 1, cnt SHALL be 0 and err SHALL be 0.
REQ-025 In SCAN with en=1, when cnt==dwell, ptr SHALL advance to the next set bit of the live ch_mask strictly above ptr, wrapping to bit 0, and cnt SHALL clear; otherwise cnt SHALL increment.
REQ-026 Each scan channel SHALL therefore be held dwell+1 enabled cycles, and dwell=0 SHALL advance every cycle.
REQ-027 If the only set bit of ch_mask is ptr, the scan SHALL remain on ptr.
REQ-028 dwell SHALL be sampled live at each comparison.
REQ-029 If ch_mask becomes 0 while in SCAN, the next edge SHALL go to HALT.
REQ-030 In HALT, dout SHALL be 0, dout_valid SHALL be 0 and err SHALL be 1.
REQ-031 HALT SHALL exit to SCAN (per REQ-024) when ch_mask becomes nonzero with mode=1, or to DIRECT when mode=0.
REQ-032 err SHALL clear on any exit from HALT.
REQ-033 Clearing a ch_mask bit for the channel currently being scanned SHALL NOT cut its dwell short.

Reset
REQ-034 When rst_n=0, the block SHALL asynchronously force state=IDLE, dout=0, dout_valid=0, err=0, ptr=0 and cnt=0.
REQ-035 In IDLE, din_ready SHALL still follow REQ-017, and the first accepted din SHALL decode per REQ-020 via the transition to DIRECT.
REQ-036 Reset asserted mid-scan or mid-accept SHALL discard the operation; after release the block SHALL behave as if freshly reset.

Verification (SEL_W=2, DWELL_W=4)
REQ-037 The bench SHALL cover: reset, then mode=0, en=1, din_valid=1 with din=0,1,2,3 on successive cycles -> dout=0001, 0010, 0100, 1000, each 1 cycle after accept, with dout_valid=1.
REQ-038 The bench SHALL cover: en=0 with din_valid=1 and din=2 while dout=0010 -> din_ready=0 and dout stays 0010.
REQ-039 The bench SHALL cover: mode=1, ch_mask=1011, dwell=1 -> dout sequence 0001, 0001, 0010, 0010, 1000, 1000, 0001, ... (skips bit 2 and wraps).
REQ-040 The bench SHALL cover: in SCAN, ch_mask driven to 0000 -> next cycle dout=0000, dout_valid=0, err=1; then ch_mask=0100 -> dout=0100, err=0.
REQ-041 The bench SHALL cover: rst_n pulsed low between clock edges mid-scan -> outputs go to 0 immediately, without waiting for a clock edge.
REQ-042 The bench SHALL cover: in SCAN, mode set to 0 with din=3 valid -> DIRECT, and dout=1000 one cycle after the accept.

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder
//   Registered one-hot decoder with two operating modes:
//     mode=0 (DIRECT): each accepted din is decoded to dout = 1 << din.
//     mode=1 (SCAN)  : dout walks round the set bits of ch_mask. Each
//                      channel is held for dwell+1 enabled cycles. An empty
//                      mask parks the block in HALT with err raised.
//   Nothing changes state while en is low.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   global enable; low freezes all state
//   mode       in   0 = direct decode, 1 = auto-scan
//   din_valid  in   din is offered
//   din        in   [SEL_W] index to decode
//   din_ready  out  din is accepted this cycle (combinational: en & ~mode)
//   ch_mask    in   [2**SEL_W] channels eligible for scan
//   dwell      in   [DWELL_W] extra cycles each scan channel is held
//   dout       out  [2**SEL_W] registered one-hot or all-zero output
//   dout_valid out  dout holds a valid decode
//   err        out  scan requested with an empty mask
module onehot_scan_decoder #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  din_valid,
    input  logic [SEL_W-1:0]      din,
    output logic                  din_ready,
    input  logic [(2**SEL_W)-1:0] ch_mask,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] dout,
    output logic                  dout_valid,
    output logic                  err
);

    localparam int N = 2**SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [N-1:0]         dout_r, dout_s;
    logic                 dout_valid_r, dout_valid_s;
    logic                 err_r, err_s;
    logic [SEL_W-1:0]     ptr_r, ptr_s;
    logic [DWELL_W-1:0]   cnt_r, cnt_s;
    logic                 mask_empty_s;

    // Single set bit at position idx; only ever produces a one-hot value.
    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Lowest set bit of mask (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_bit(input logic [N-1:0] mask);
        logic [SEL_W-1:0] res;
        logic             found;
        res   = {SEL_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && mask[i]) begin
                res   = SEL_W'(i);
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    // Next set bit strictly above ptr, searching circularly so the walk wraps
    // back through bit 0. If no other bit is set the pointer stays put, which
    // keeps a single-channel scan parked on that channel.
    function automatic logic [SEL_W-1:0] next_bit(input logic [N-1:0]     mask,
                                                  input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] res;
        logic [SEL_W-1:0] idx;
        logic             found;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i < N; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    assign mask_empty_s = (ch_mask == {N{1'b0}});
    assign din_ready    = en & ~mode;

    // Next-state and next-output logic; every register holds unless a branch updates it.
    always_comb begin
        state_s      = state_r;
        dout_s       = dout_r;
        dout_valid_s = dout_valid_r;
        err_s        = err_r;
        ptr_s        = ptr_r;
        cnt_s        = cnt_r;

        if (en) begin
            if (!mode) begin
                // Direct mode wins from any state; the edge that enters DIRECT
                // already decodes din when it is offered.
                state_s = DIRECT;
                err_s   = 1'b0;
                if (din_valid) begin
                    dout_s       = onehot(din);
                    dout_valid_s = 1'b1;
                end else begin
                    dout_s       = dout_r;
                    dout_valid_s = dout_valid_r;
                end
            end else if (state_r == SCAN) begin
                if (mask_empty_s) begin
                    state_s      = HALT;
                    dout_s       = {N{1'b0}};
                    dout_valid_s = 1'b0;
                    err_s        = 1'b1;
                end else if (cnt_r == dwell) begin
                    // The dwell runs out on the current channel even if its
                    // mask bit has been cleared meanwhile.
                    ptr_s  = next_bit(ch_mask, ptr_r);
                    dout_s = onehot(next_bit(ch_mask, ptr_r));
                    cnt_s  = {DWELL_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + DWELL_W'(1);
                end
            end else begin
                if (mask_empty_s) begin
                    state_s      = HALT;
                    dout_s       = {N{1'b0}};
                    dout_valid_s = 1'b0;
                    err_s        = 1'b1;
                end else begin
                    state_s      = SCAN;
                    ptr_s        = lowest_bit(ch_mask);
                    dout_s       = onehot(lowest_bit(ch_mask));
                    dout_valid_s = 1'b1;
                    cnt_s        = {DWELL_W{1'b0}};
                    err_s        = 1'b0;
                end
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            dout_r       <= {N{1'b0}};
            dout_valid_r <= 1'b0;
            err_r        <= 1'b0;
            ptr_r        <= {SEL_W{1'b0}};
            cnt_r        <= {DWELL_W{1'b0}};
        end else begin
            state_r      <= state_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            err_r        <= err_s;
            ptr_r        <= ptr_s;
            cnt_r        <= cnt_s;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign err        = err_r;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed testbench for onehot_scan_decoder (SEL_W=2, DWELL_W=4).
module tb_onehot_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       din_valid;
    logic [1:0] din;
    logic       din_ready;
    logic [3:0] ch_mask;
    logic [3:0] dwell;
    logic [3:0] dout;
    logic       dout_valid;
    logic       err;

    int n_checks;
    int n_pass;

    onehot_scan_decoder #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .dout       (dout),
        .dout_valid (dout_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] direct_exp [4];
    logic [3:0] scan_exp   [8];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        direct_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        scan_exp   = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                       4'b1000, 4'b1000, 4'b0001, 4'b0001};

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; din_valid = 1'b0; din = 2'd0;
        ch_mask = 4'b0000; dwell = 4'd0;
        #12;
        check("rst_dout",  {28'd0, dout}, 32'h0);
        check("rst_valid", {31'd0, dout_valid}, 32'h0);
        check("rst_err",   {31'd0, err}, 32'h0);
        check("rst_ready", {31'd0, din_ready}, 32'h0);
        rst_n = 1'b1;
        step();

        // Direct decode, first accept from IDLE.
        en = 1'b1; mode = 1'b0; din_valid = 1'b1;
        #1;
        check("ready_direct", {31'd0, din_ready}, 32'h1);
        for (int d = 0; d < 4; d++) begin
            din = 2'(d);
            step();
            check($sformatf("direct_dout%0d", d), {28'd0, dout}, {28'd0, direct_exp[d]});
            check($sformatf("direct_valid%0d", d), {31'd0, dout_valid}, 32'h1);
        end

        // Freeze with en=0 while dout=0010.
        din = 2'd1;
        step();
        check("direct_d1", {28'd0, dout}, 32'h2);
        en = 1'b0; din = 2'd2;
        #1;
        check("freeze_ready", {31'd0, din_ready}, 32'h0);
        step();
        step();
        check("freeze_dout", {28'd0, dout}, 32'h2);

        // Enabled, no accept: hold.
        en = 1'b1; din_valid = 1'b0;
        step();
        check("direct_hold", {28'd0, dout}, 32'h2);

        // Scan 1011 with dwell 1.
        mode = 1'b1; ch_mask = 4'b1011; dwell = 4'd1;
        #1;
        check("ready_scan", {31'd0, din_ready}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("scan_seq%0d", k), {28'd0, dout}, {28'd0, scan_exp[k]});
        end
        check("scan_valid", {31'd0, dout_valid}, 32'h1);
        check("scan_err",   {31'd0, err}, 32'h0);

        // Freeze mid-scan (ptr=0, cnt=1), then resume.
        en = 1'b0;
        step();
        step();
        check("scan_freeze", {28'd0, dout}, 32'h1);
        en = 1'b1;
        step();
        check("scan_resume", {28'd0, dout}, 32'h2);

        // dwell=0 advances every cycle.
        dwell = 4'd0;
        step();
        check("dwell0_a", {28'd0, dout}, 32'h8);
        step();
        check("dwell0_b", {28'd0, dout}, 32'h1);
        step();
        check("dwell0_c", {28'd0, dout}, 32'h2);

        // Empty mask -> HALT, then recover with 0100.
        ch_mask = 4'b0000;
        step();
        check("halt_dout",  {28'd0, dout}, 32'h0);
        check("halt_valid", {31'd0, dout_valid}, 32'h0);
        check("halt_err",   {31'd0, err}, 32'h1);
        step();
        check("halt_stay",  {31'd0, err}, 32'h1);
        ch_mask = 4'b0100;
        step();
        check("rescan_dout",  {28'd0, dout}, 32'h4);
        check("rescan_err",   {31'd0, err}, 32'h0);
        check("rescan_valid", {31'd0, dout_valid}, 32'h1);
        step();
        check("single_bit", {28'd0, dout}, 32'h4);

        // Async reset between edges mid-scan.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_dout",  {28'd0, dout}, 32'h0);
        check("async_valid", {31'd0, dout_valid}, 32'h0);
        check("async_err",   {31'd0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ch_mask = 4'b0001;
        step();
        check("post_rst_scan", {28'd0, dout}, 32'h1);

        // SCAN -> DIRECT with din=3 accepted.
        mode = 1'b0; din = 2'd3; din_valid = 1'b1;
        step();
        check("scan2direct",       {28'd0, dout}, 32'h8);
        check("scan2direct_valid", {31'd0, dout_valid}, 32'h1);

        // Clearing the current channel's bit does not cut its dwell short.
        din_valid = 1'b0; mode = 1'b1; ch_mask = 4'b0011; dwell = 4'd2;
        step();
        check("cut_entry", {28'd0, dout}, 32'h1);
        step();
        ch_mask = 4'b0010;
        step();
        check("cut_hold", {28'd0, dout}, 32'h1);
        step();
        check("cut_adv", {28'd0, dout}, 32'h2);

        // HALT -> DIRECT without accept clears err, keeps dout zero.
        ch_mask = 4'b0000;
        step();
        check("halt2_err", {31'd0, err}, 32'h1);
        mode = 1'b0;
        step();
        check("h2d_err",   {31'd0, err}, 32'h0);
        check("h2d_dout",  {28'd0, dout}, 32'h0);
        check("h2d_valid", {31'd0, dout_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
